// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-way traffic-light controller:
// lamp codes, phase encoding, default phase durations and the lamp decoder.
package semaforo_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [7:0] T_VERDE_DEF    = 8'd1;
    localparam logic [7:0] T_AMARELO_DEF  = 8'd3;
    localparam logic [7:0] T_VERMELHO_DEF = 8'd2;

    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } lamps_t;

    function automatic lamps_t decode(input phase_t p);
        lamps_t l;
        case (p)
            P0:      l = '{a: GREEN,  b: RED};
            P1:      l = '{a: YELLOW, b: RED};
            P2:      l = '{a: RED,    b: GREEN};
            default: l = '{a: RED,    b: YELLOW};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Loadable 8-bit down-counter with zero flag; holds at zero until reloaded.
module semaforo_timer #(
    parameter logic [7:0] RST_VAL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] cnt,
    output logic       zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-way traffic-light controller: 4-phase timed cycle with a request
// button that cuts A's green short. Lamp outputs are registered.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter logic [7:0] T_VERDE    = T_VERDE_DEF,
    parameter logic [7:0] T_AMARELO  = T_AMARELO_DEF,
    parameter logic [7:0] T_VERMELHO = T_VERMELHO_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    if (T_VERDE == 8'd0 || T_AMARELO == 8'd0 || T_VERMELHO == 8'd0) begin : g_bad_param
        $error("semaforo_ctrl: phase durations must be 1..255");
    end

    phase_t     phase, phase_nxt;
    logic       req, req_nxt;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic       zero;
    lamps_t     lamps_nxt;

    semaforo_timer #(.RST_VAL(T_VERDE - 8'd1)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    always_comb begin
        phase_nxt = phase;
        load      = 1'b0;
        load_val  = 8'd0;
        req_nxt   = req | bt;

        if (phase == P0 && !zero && (req | bt)) begin
            phase_nxt = P1;
            load      = 1'b1;
            load_val  = T_AMARELO - 8'd1;
        end else if (zero) begin
            load = 1'b1;
            case (phase)
                P0: begin phase_nxt = P1; load_val = T_AMARELO - 8'd1;  end
                P1: begin phase_nxt = P2; load_val = T_VERMELHO - 8'd1; end
                P2: begin phase_nxt = P3; load_val = T_AMARELO - 8'd1;  end
                default: begin phase_nxt = P0; load_val = T_VERDE - 8'd1; end
            endcase
        end

        // A pending request is consumed when the yellow it asked for begins.
        if (phase_nxt == P1 && phase != P1)
            req_nxt = 1'b0;

        lamps_nxt = decode(phase_nxt);
    end

    // Lamps are decoded from the next phase so the registers track phase exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= P0;
            req   <= 1'b0;
            A     <= GREEN;
            B     <= RED;
        end else begin
            phase <= phase_nxt;
            req   <= req_nxt;
            A     <= lamps_nxt.a;
            B     <= lamps_nxt.b;
        end
    end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench: three controller configurations driven by a shared
// button, compared against a phase/elapsed-time reference model.
module tb_semaforo_ctrl;

    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b100;

    typedef struct {
        int phase;
        int elapsed;
        bit req;
    } model_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bt  = 1'b0;
    logic [2:0] a_def, b_def, a_v5, b_v5, a_t1, b_t1;

    int checks = 0;
    int errors = 0;

    int     dur [3][4];
    model_t m   [3];
    int     t1_cyc;

    always #5 clk = ~clk;

    semaforo_ctrl dut_def (.clk(clk), .rst(rst), .bt(bt), .A(a_def), .B(b_def));
    semaforo_ctrl #(.T_VERDE(8'd5)) dut_v5 (.clk(clk), .rst(rst), .bt(bt), .A(a_v5), .B(b_v5));
    semaforo_ctrl #(.T_VERDE(8'd1), .T_AMARELO(8'd1), .T_VERMELHO(8'd1)) dut_t1
        (.clk(clk), .rst(rst), .bt(bt), .A(a_t1), .B(b_t1));

    function automatic logic [2:0] lamp_a(input int ph);
        return (ph == 0) ? LG : (ph == 1) ? LY : LR;
    endfunction

    function automatic logic [2:0] lamp_b(input int ph);
        return (ph == 2) ? LG : (ph == 3) ? LY : LR;
    endfunction

    function automatic model_t model_step(input model_t s, input int k, input bit b);
        model_t n = s;
        bit last = (s.elapsed == dur[k][s.phase] - 1);
        if (s.phase == 0 && !last && (s.req || b)) begin
            n.phase = 1; n.elapsed = 0; n.req = 0;
        end else if (last) begin
            n.phase   = (s.phase + 1) % 4;
            n.elapsed = 0;
            n.req     = (n.phase == 1) ? 1'b0 : (s.req | b);
        end else begin
            n.elapsed = s.elapsed + 1;
            n.req     = s.req | b;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " def.A"}, a_def, lamp_a(m[0].phase));
        check({tag, " def.B"}, b_def, lamp_b(m[0].phase));
        check({tag, " v5.A"},  a_v5,  lamp_a(m[1].phase));
        check({tag, " v5.B"},  b_v5,  lamp_b(m[1].phase));
        check({tag, " t1.A"},  a_t1,  lamp_a(t1_cyc % 4));
        check({tag, " t1.B"},  b_t1,  lamp_b(t1_cyc % 4));
    endtask

    task automatic step(input bit b, input string tag);
        bt = b;
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = model_step(m[k], k, b);
        t1_cyc++;
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m[k] = '{phase: 0, elapsed: 0, req: 1'b0};
        t1_cyc = 0;
    endtask

    // Called just after a rising edge; the whole pulse sits between edges.
    task automatic pulse_reset();
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 1'b1;
    endtask

    function automatic bit lamps_ok(input logic [2:0] a, input logic [2:0] b);
        return $onehot(a) && $onehot(b) && (a == LR || b == LR);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            assert (lamps_ok(a_def, b_def) && lamps_ok(a_v5, b_v5) && lamps_ok(a_t1, b_t1)) else begin
                errors++;
                $error("FAIL lamp_safety observed def=%b/%b v5=%b/%b t1=%b/%b expected one-hot with a RED",
                       a_def, b_def, a_v5, b_v5, a_t1, b_t1);
            end
        end
    end

    logic [2:0] seq_a [9];
    logic [2:0] seq_b [9];
    int         guard;

    initial begin
        dur[0] = '{1, 3, 2, 3};
        dur[1] = '{5, 3, 2, 3};
        dur[2] = '{1, 1, 1, 1};
        seq_a = '{LG, LY, LY, LY, LR, LR, LR, LR, LR};
        seq_b = '{LR, LR, LR, LR, LG, LG, LY, LY, LY};
        model_reset();

        // Reset state and the default 9-cycle sequence.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        for (int c = 0; c < 18; c++) begin
            check($sformatf("seq%0d.A", c), a_def, seq_a[c % 9]);
            check($sformatf("seq%0d.B", c), b_def, seq_b[c % 9]);
            step(1'b0, "seq");
        end

        // Button at P0 cycle 2 of a 5-cycle green gives early yellow on that edge.
        pulse_reset();
        step(1'b0, "early_pre");
        check("early_p0c2", a_v5, LG);
        step(1'b1, "early");
        check("early_yellow", a_v5, LY);
        checks++;
        assert (dut_v5.req === 1'b0) else begin
            errors++;
            $error("FAIL early_req_clear observed=%b expected=0", dut_v5.req);
        end

        // Button during P2 makes the following P0 one cycle long.
        guard = 0;
        while (m[1].phase != 2 && guard < 20) begin step(1'b0, "to_p2"); guard++; end
        check("reached_p2", a_v5, LR);
        step(1'b1, "bt_p2");
        guard = 0;
        while (m[1].phase != 0 && guard < 20) begin step(1'b0, "to_p0"); guard++; end
        check("short_p0_entry", a_v5, LG);
        step(1'b0, "short_p0");
        check("short_p0_exit", a_v5, LY);
        repeat (2) step(1'b0, "p1_normal");
        check("p1_full", a_v5, LY);
        step(1'b0, "p1_end");
        check("p1_end", a_v5, LR);

        // Asynchronous reset in the middle of P2, then a full-length P0.
        guard = 0;
        while (m[1].phase != 2 && guard < 20) begin step(1'b0, "to_p2b"); guard++; end
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, "full_p0");
            check($sformatf("full_p0_c%0d", c + 2), a_v5, LG);
        end
        step(1'b0, "full_p0_end");
        check("full_p0_end", a_v5, LY);

        // Random button activity against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom_range(0, 3) == 0) ? 1 : 0), "rand");
            if (i == 200) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
